// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared opmode bit indices and pipeline latency for the DSP MAC
package dsp_pkg;

  localparam int OPM_PREADD  = 0;
  localparam int OPM_PRESUB  = 1;
  localparam int OPM_POSTSUB = 2;

  localparam int DSP_MAC_LATENCY = 4;

endpackage

// File: rtl/dsp_acc_add.sv
// rtl/dsp_acc_add.sv - signed add/sub with overflow flag; clamps when DSP_MAC_SAT_EN is defined
module dsp_acc_add #(
  parameter int WIDTH = 48
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    sub,
  output logic signed [WIDTH-1:0] sum,
  output logic                    ovf
);

  logic signed [WIDTH-1:0] raw;

  // Overflow from operand and result signs (equivalent to carry-in vs carry-out of the sign bit);
  // the overflow direction always follows the sign of a, which selects the clamp value.
  always_comb begin
    raw = sub ? (a - b) : (a + b);
    if (sub)
      ovf = (a[WIDTH-1] != b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
    else
      ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
`ifdef DSP_MAC_SAT_EN
    if (ovf)
      sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      sum = raw;
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/dsp_mac_acc.sv
// rtl/dsp_mac_acc.sv - 4-stage pre-add/multiply/framed-accumulate engine (saturation via DSP_MAC_SAT_EN)
module dsp_mac_acc
  import dsp_pkg::*;
#(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int P_WIDTH   = 48,
  parameter int CNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        RST,
  input  logic                        CE,
  input  logic                        in_valid,
  input  logic                        in_first,
  input  logic                        in_last,
  input  logic [2:0]                  opmode,
  input  logic signed [A_WIDTH-1:0]   A,
  input  logic signed [B_WIDTH-1:0]   B,
  input  logic signed [B_WIDTH-1:0]   D,
  input  logic signed [P_WIDTH-1:0]   C,
  output logic                        out_valid,
  output logic signed [P_WIDTH-1:0]   P,
  output logic [CNT_WIDTH-1:0]        count,
  output logic                        overflow
);

  localparam int PB_WIDTH = B_WIDTH + 1;
  localparam int M_WIDTH  = A_WIDTH + B_WIDTH + 1;

  // stage 1
  logic signed [A_WIDTH-1:0]  a1;
  logic signed [B_WIDTH-1:0]  b1, d1;
  logic signed [P_WIDTH-1:0]  c1;
  logic [2:0]                 op1;
  logic                       v1, f1, l1;
  // stage 2
  logic signed [PB_WIDTH-1:0] b_pre, bp2;
  logic signed [A_WIDTH-1:0]  a2;
  logic signed [P_WIDTH-1:0]  c2;
  logic                       sub2, v2, f2, l2;
  // stage 3
  logic signed [M_WIDTH-1:0]  m3;
  logic signed [P_WIDTH-1:0]  c3;
  logic                       sub3, v3, f3, l3;
  // stage 4
  logic signed [P_WIDTH-1:0]  acc, base, m_ext, sum;
  logic [CNT_WIDTH-1:0]       cnt_acc, cnt_next;
  logic                       ovf_acc, ovf_next, add_ovf, active, start;

  // Stage 1: capture inputs; frame markers only count on valid beats
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      a1 <= '0; b1 <= '0; d1 <= '0; c1 <= '0; op1 <= '0;
      v1 <= 1'b0; f1 <= 1'b0; l1 <= 1'b0;
    end else if (CE) begin
      a1  <= A;
      b1  <= B;
      d1  <= D;
      c1  <= C;
      op1 <= opmode;
      v1  <= in_valid;
      f1  <= in_valid & in_first;
      l1  <= in_valid & in_last;
    end
  end

  // Pre-adder at one extra bit so D+B / D-B never wraps
  always_comb begin
    b_pre = PB_WIDTH'(b1);
    if (op1[OPM_PREADD]) begin
      if (op1[OPM_PRESUB])
        b_pre = PB_WIDTH'(d1) - PB_WIDTH'(b1);
      else
        b_pre = PB_WIDTH'(d1) + PB_WIDTH'(b1);
    end
  end

  // Stage 2: register pre-adder result and forward the rest
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      bp2 <= '0; a2 <= '0; c2 <= '0;
      sub2 <= 1'b0; v2 <= 1'b0; f2 <= 1'b0; l2 <= 1'b0;
    end else if (CE) begin
      bp2  <= b_pre;
      a2   <= a1;
      c2   <= c1;
      sub2 <= op1[OPM_POSTSUB];
      v2   <= v1;
      f2   <= f1;
      l2   <= l1;
    end
  end

  // Stage 3: full-precision signed product (the true product always fits M_WIDTH)
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      m3 <= '0; c3 <= '0;
      sub3 <= 1'b0; v3 <= 1'b0; f3 <= 1'b0; l3 <= 1'b0;
    end else if (CE) begin
      m3   <= M_WIDTH'(a2) * M_WIDTH'(bp2);
      c3   <= c2;
      sub3 <= sub2;
      v3   <= v2;
      f3   <= f2;
      l3   <= l2;
    end
  end

  // Frame start reloads from the bias; count saturates at all-ones; overflow is sticky within a frame
  always_comb begin
    start    = f3 | ~active;
    base     = start ? c3 : acc;
    m_ext    = P_WIDTH'(m3);
    cnt_next = start ? CNT_WIDTH'(1) :
               ((cnt_acc == '1) ? cnt_acc : cnt_acc + CNT_WIDTH'(1));
    ovf_next = (start ? 1'b0 : ovf_acc) | add_ovf;
  end

  dsp_acc_add #(
    .WIDTH (P_WIDTH)
  ) u_acc_add (
    .a   (base),
    .b   (m_ext),
    .sub (sub3),
    .sum (sum),
    .ovf (add_ovf)
  );

  // Stage 4: accumulate on valid beats, publish and close the frame on last
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      acc <= '0; cnt_acc <= '0; ovf_acc <= 1'b0; active <= 1'b0;
      P <= '0; count <= '0; overflow <= 1'b0; out_valid <= 1'b0;
    end else if (CE) begin
      out_valid <= v3 & l3;
      if (v3) begin
        acc     <= sum;
        cnt_acc <= cnt_next;
        ovf_acc <= ovf_next;
        active  <= ~l3;
        if (l3) begin
          P        <= sum;
          count    <= cnt_next;
          overflow <= ovf_next;
        end
      end
    end
  end

endmodule

// File: doc/dsp_mac_acc.md
# dsp_mac_acc

Parametrised successor to the fixed-width DSP slice. It is a pipelined pre-add / multiply / accumulate engine with generic operand widths and valid-qualified samples. It adds framed accumulation (first/last markers), a per-frame product count, sticky overflow detection and optional saturation. It sits in the datapath wherever a filter tap sum or dot product is needed, fed by upstream sample logic.

## Interface
Parameters:
- A_WIDTH, 18, signed multiplier operand A width
- B_WIDTH, 18, signed B and D width; the pre-adder output is B_WIDTH+1
- P_WIDTH, 48, accumulator/result width; must be >= A_WIDTH+B_WIDTH+1
- CNT_WIDTH, 8, product-count width

Ports:
- clk  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset of every register
- CE  in  1  global clock enable; low = all stages hold, inputs not sampled
- in_valid  in  1  sample qualifier
- in_first  in  1  sample opens a new frame (valid-qualified)
- in_last  in  1  sample closes the frame (valid-qualified)
- opmode  in  3  [0] pre-add enable, [1] pre-subtract, [2] post-subtract
- A  in  A_WIDTH  signed
- B  in  B_WIDTH  signed
- D  in  B_WIDTH  signed
- C  in  P_WIDTH  signed bias, sampled only with in_first
- out_valid  out  1  one-cycle result pulse
- P  out  P_WIDTH  frame result, held until the next result
- count  out  CNT_WIDTH  products in the frame; saturates at all-ones
- overflow  out  1  sticky per frame, reported with P

## Operation
- **Stage 1:** register A, B, D, C, opmode, and the first/last/valid flags.
- **Stage 2:** compute B' and register it.
  - opmode[0]=0: B' = B, sign-extended.
  - opmode[0]=1: B' = D+B, or D−B when opmode[1]=1.
  - Width is B_WIDTH+1, so the pre-add never wraps.
- **Stage 3:** M = A·B', signed, width A_WIDTH+B_WIDTH+1, registered.
- **Stage 4:** accumulator.
  - State bit `active`; the idle/active transitions follow.
  - First beat (in_first, or any valid beat while idle): acc = C ± sext(M); count=1; overflow cleared and then set from this addition; active=1.
  - Subsequent beats while active: acc = acc ± sext(M); count++.
  - `±` is − when the registered opmode[2]=1.
  - Beat with in_last: P, count and overflow are loaded from the new values; out_valid=1; active=0.
  - in_first and in_last on the same beat: single-product frame, P = C ± M.
  - in_first while active: the open frame is discarded with no output, and the new frame starts.
  - Overflow is a signed carry into versus out of the sign bit of the P_WIDTH add. It is sticky until the next frame start.
  - Beats with in_valid low leave every stage-4 register unchanged.
- **Reset:** P=0, count=0, overflow=0, out_valid=0, active=0, and all pipeline registers and valid bits are 0. A frame in flight is lost; no partial result is emitted.

## Timing
- Latency is 4 enabled cycles: a beat sampled at edge t with in_last produces out_valid high in the cycle after edge t+3 (CE high throughout).
- Full throughput: one beat per cycle, with no gaps required.
- CE low freezes every register including out_valid, so a pulse stretches while CE is low. Downstream must qualify out_valid with CE.
- RST is asynchronous assert. Release is synchronous to clk externally; no internal synchroniser.

## Configuration
- DSP_MAC_SAT_EN defined:
  - On overflow, the stage-4 sum clamps to the signed max (2^(P_WIDTH−1)−1) or min (−2^(P_WIDTH−1)), per the overflow direction.
  - Accumulation continues from the clamped value.
  - overflow is still reported.
- DSP_MAC_SAT_EN undefined: two's-complement wrap; overflow is still reported.

## Structure
- Shared package dsp_pkg holds:
  - opmode bit-index localparams: OPM_PREADD=0, OPM_PRESUB=1, OPM_POSTSUB=2.
  - DSP_MAC_LATENCY=4.
- Sub-module dsp_acc_add: P_WIDTH signed add/sub with overflow output and the DSP_MAC_SAT_EN clamp. It is instantiated once in stage 4.

## Test plan
- **Single-product frame, defaults:** A=3, B=4, C=10, opmode=000, first+last → out_valid 4 cycles later, P=22, count=1, overflow=0.
- **Pre-adder:** A=−3, D=5, B=2, single-product frames, C=0.
  - opmode=001 → P=−21.
  - opmode=011 → P=−9.
  - opmode=111 → P=+9.
- **Framed accumulation:** B=2, A=1..4 on 4 beats, C=0, idle cycles between beats 2 and 3 → single out_valid, P=20, count=4.
  - An immediate back-to-back second frame is still correct.
- **Overflow, A_WIDTH=B_WIDTH=10, P_WIDTH=21:** two beats with A=−512, D=−512, B=512, opmode=011, C=0.
  - Each product is 524288.
  - Without DSP_MAC_SAT_EN: P=−1048576, overflow=1.
  - With DSP_MAC_SAT_EN: P=1048575, overflow=1.
- **Restart, CE and reset:**
  - in_first mid-frame → only the second frame's result is emitted.
  - CE low for 3 cycles mid-stream → result equals the CE-always-high run, shifted by 3 cycles.
  - RST pulse mid-frame → all outputs 0 immediately and no out_valid for that frame.
